// File: rtl/hub75_pkg.sv
//------------------------------------------------------------------------------
// hub75_pkg
//   Shared definitions for the LED-matrix scan capture block: geometry
//   defaults, the pixel type and the capture FSM state encoding.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hub75_pkg;

  // Default panel geometry: 32 pixels per row load, 8 row-pair addresses
  // (16 physical rows).
  localparam int COLS_DEFAULT      = 32;
  localparam int SCAN_ROWS_DEFAULT = 8;

  // One displayed pixel, {B,G,R}.
  typedef logic [2:0] rgb_t;

  // Capture FSM states.
  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } cap_state_t;

endpackage : hub75_pkg

`default_nettype wire

// File: rtl/hub75_edge_sync.sv
//------------------------------------------------------------------------------
// hub75_edge_sync
//   Two-stage registering of the pixel shift clock and the row latch, with
//   rising-edge detection (edge = s1 & ~s2).
//   Ports:
//     clk_i, reset_i     : system clock, synchronous active-high reset
//     outclk_i, lat_i    : raw scan-interface pins
//     outclk_rise_o      : one-cycle pulse on an outclk rising edge
//     lat_rise_o         : one-cycle pulse on a lat rising edge
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hub75_edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic outclk_i,
  input  logic lat_i,
  output logic outclk_rise_o,
  output logic lat_rise_o
);

  logic outclk_s1_q, outclk_s2_q;
  logic lat_s1_q, lat_s2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outclk_s1_q <= 1'b0;
      outclk_s2_q <= 1'b0;
      lat_s1_q    <= 1'b0;
      lat_s2_q    <= 1'b0;
    end else begin
      outclk_s1_q <= outclk_i;
      outclk_s2_q <= outclk_s1_q;
      lat_s1_q    <= lat_i;
      lat_s2_q    <= lat_s1_q;
    end
  end

  assign outclk_rise_o = outclk_s1_q & ~outclk_s2_q;
  assign lat_rise_o    = lat_s1_q & ~lat_s2_q;

endmodule : hub75_edge_sync

`default_nettype wire

// File: rtl/hub75_capture.sv
//------------------------------------------------------------------------------
// hub75_capture
//   Receive-side model of the LED-matrix scan interface. Samples the
//   rgb/outclk/lat/oe/abc stream produced by a display driver in the same
//   clock domain and rebuilds the frame it represents. Captured pixels are
//   exposed through a registered read port; sticky flags report protocol
//   violations.
//
//   Optional feature macro: HUB75_CAPTURE_OE_CHECK_EN
//     defined   : a lat rise seen while the display is enabled (oe low)
//                 sets oe_err_o; the commit itself proceeds normally.
//     undefined : oe_i is ignored and oe_err_o is tied low.
//
//   Ports:
//     clk_i, reset_i   : system clock, synchronous active-high reset
//     rgb_i[5:0]       : [2:0] upper-half pixel, [5:3] lower-half pixel
//     outclk_i         : pixel shift clock (data taken on its rising edge)
//     lat_i            : row latch (rising edge commits the row)
//     oe_i             : output enable, active low
//     abc_i            : row-pair address
//     rd_row_i/rd_col_i: frame read address
//     rd_rgb_o         : captured pixel {B,G,R}, one cycle read latency
//     frame_done_o     : one-cycle pulse after a complete frame
//     frame_cnt_o      : completed-frame counter, wraps
//     len_err_o        : sticky, latch with shift count != COLS
//     oe_err_o         : sticky, latch while display enabled
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hub75_capture
  import hub75_pkg::*;
#(
  parameter int COLS      = COLS_DEFAULT,
  parameter int SCAN_ROWS = SCAN_ROWS_DEFAULT,
  localparam int AW = $clog2(SCAN_ROWS),
  localparam int RW = $clog2(2 * SCAN_ROWS),
  localparam int CW = $clog2(COLS),
  localparam int NW = $clog2(COLS + 2)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [5:0]    rgb_i,
  input  logic          outclk_i,
  input  logic          lat_i,
  input  logic          oe_i,
  input  logic [AW-1:0] abc_i,
  input  logic [RW-1:0] rd_row_i,
  input  logic [CW-1:0] rd_col_i,
  output logic [2:0]    rd_rgb_o,
  output logic          frame_done_o,
  output logic [15:0]   frame_cnt_o,
  output logic          len_err_o,
  output logic          oe_err_o
);

  localparam int NROWS = 2 * SCAN_ROWS;

  // --------------------------------------------------------------------------
  // Input staging: s1 copies of the data pins line up with the edge pulses.
  // --------------------------------------------------------------------------
  logic          outclk_rise, lat_rise;
  logic [5:0]    rgb_s1_q;
  logic [AW-1:0] abc_s1_q;

  hub75_edge_sync u_edge_sync (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .outclk_i      (outclk_i),
    .lat_i         (lat_i),
    .outclk_rise_o (outclk_rise),
    .lat_rise_o    (lat_rise)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rgb_s1_q <= '0;
      abc_s1_q <= '0;
    end else begin
      rgb_s1_q <= rgb_i;
      abc_s1_q <= abc_i;
    end
  end

  // --------------------------------------------------------------------------
  // Capture state
  // --------------------------------------------------------------------------
  cap_state_t         state_q;
  logic [5:0]         sreg_q [COLS];
  logic [NW-1:0]      cnt_q;
  logic [AW-1:0]      abc_q;        // row-pair address captured at the lat rise
  logic [SCAN_ROWS-1:0] mask_q;
  logic [SCAN_ROWS-1:0] mask_d;
  rgb_t               frame_q [NROWS][COLS];
  logic               frame_done_q;
  logic [15:0]        frame_cnt_q;
  logic               len_err_q;
  rgb_t               rd_rgb_q;

  logic [RW-1:0] row_hi_d, row_lo_d;
  logic          shift_en_d;

  always_comb begin
    mask_d     = mask_q | (SCAN_ROWS'(1) << abc_q);
    row_hi_d   = RW'(abc_q);
    row_lo_d   = RW'(abc_q) + RW'(SCAN_ROWS);
    // Pixels are ignored until the first latch has aligned us to a row.
    shift_en_d = outclk_rise && (state_q != ST_SYNC);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_SYNC;
      cnt_q        <= '0;
      abc_q        <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      len_err_q    <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        sreg_q[c] <= '0;
      end
      for (int r = 0; r < NROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          frame_q[r][c] <= '0;
        end
      end
    end else begin
      frame_done_q <= 1'b0;

      // New pixels enter at column 0 and move toward COLS-1, so after a
      // full row the first pixel shifted sits at the last column.
      if (shift_en_d) begin
        for (int c = COLS - 1; c > 0; c--) begin
          sreg_q[c] <= sreg_q[c-1];
        end
        sreg_q[0] <= rgb_s1_q;
      end

      unique case (state_q)
        ST_SYNC: begin
          if (lat_rise) begin
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // Saturate one past COLS so an over-long row stays detectable.
          if (shift_en_d && (cnt_q != NW'(COLS + 1))) begin
            cnt_q <= cnt_q + NW'(1);
          end
          // A shift in the same cycle is already folded into sreg/cnt by
          // the time COMMIT evaluates them.
          if (lat_rise) begin
            abc_q   <= abc_s1_q;
            state_q <= ST_COMMIT;
          end
        end

        ST_COMMIT: begin
          if (cnt_q == NW'(COLS)) begin
            for (int c = 0; c < COLS; c++) begin
              frame_q[row_hi_d][c] <= sreg_q[c][2:0];
              frame_q[row_lo_d][c] <= sreg_q[c][5:3];
            end
            if (&mask_d) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 16'd1;
              mask_q       <= '0;
            end else begin
              mask_q <= mask_d;
            end
          end else begin
            len_err_q <= 1'b1;
          end
          // A pixel arriving during COMMIT is the first of the next row.
          cnt_q   <= shift_en_d ? NW'(1) : NW'(0);
          state_q <= ST_SHIFT;
        end

        default: begin
          state_q <= ST_SYNC;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port. A same-cycle commit is not bypassed, so a read of
  // the row being written returns its previous contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_rgb_q <= '0;
    end else begin
      rd_rgb_q <= frame_q[rd_row_i][rd_col_i];
    end
  end

  // --------------------------------------------------------------------------
  // Optional latch-while-enabled check
  // --------------------------------------------------------------------------
`ifdef HUB75_CAPTURE_OE_CHECK_EN
  logic oe_s1_q;
  logic oe_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      oe_s1_q  <= 1'b1;
      oe_err_q <= 1'b0;
    end else begin
      oe_s1_q <= oe_i;
      if (lat_rise && !oe_s1_q) begin
        oe_err_q <= 1'b1;
      end
    end
  end

  assign oe_err_o = oe_err_q;
`else
  logic unused_oe;
  assign unused_oe = oe_i;
  assign oe_err_o  = 1'b0;
`endif

  assign rd_rgb_o     = rd_rgb_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign len_err_o    = len_err_q;

endmodule : hub75_capture

`default_nettype wire

// File: tb/tb_hub75_capture.sv
//------------------------------------------------------------------------------
// tb_hub75_capture
//   Randomized scoreboard bench for hub75_capture. A reference frame model
//   kept as plain arrays/queues predicts every read; reads push their
//   expectation into a queue that an independent monitor pops and compares
//   when the registered read data becomes valid.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hub75_capture;

  localparam int COLS = 32;
  localparam int SR   = 8;
  localparam int NR   = 16;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [5:0] rgb    = '0;
  logic       outclk = 1'b0;
  logic       lat    = 1'b0;
  logic       oe     = 1'b1;
  logic [2:0] abc    = '0;
  logic [3:0] rd_row = '0;
  logic [4:0] rd_col = '0;

  wire [2:0]  rd_rgb;
  wire        frame_done;
  wire [15:0] frame_cnt;
  wire        len_err;
  wire        oe_err;

  always #5 clk = ~clk;

  hub75_capture #(.COLS(COLS), .SCAN_ROWS(SR)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .rgb_i        (rgb),
    .outclk_i     (outclk),
    .lat_i        (lat),
    .oe_i         (oe),
    .abc_i        (abc),
    .rd_row_i     (rd_row),
    .rd_col_i     (rd_col),
    .rd_rgb_o     (rd_rgb),
    .frame_done_o (frame_done),
    .frame_cnt_o  (frame_cnt),
    .len_err_o    (len_err),
    .oe_err_o     (oe_err)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // ---------------- reference model ----------------
  logic [2:0] m_fr [NR][COLS];
  logic [5:0] m_px [$];
  bit   [SR-1:0] m_mask;
  bit   m_sync, m_len, m_oe;
  int   m_frames;      // frame counter (cleared by reset)
  int   m_done;        // total frame_done pulses expected over the run

  function automatic void m_reset();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < COLS; c++) m_fr[r][c] = '0;
    m_px.delete();
    m_mask = '0; m_sync = 0; m_len = 0; m_oe = 0; m_frames = 0;
  endfunction

  function automatic void m_pix(logic [5:0] d);
    if (m_sync) m_px.push_back(d);
  endfunction

  function automatic void m_latch(int a, logic oev);
`ifdef HUB75_CAPTURE_OE_CHECK_EN
    if (!oev) m_oe = 1;
`endif
    if (!m_sync) begin
      m_sync = 1;
      m_px.delete();
      return;
    end
    if (m_px.size() == COLS) begin
      // Pixel i (0 = first shifted) ends up at column COLS-1-i.
      for (int i = 0; i < COLS; i++) begin
        m_fr[a][COLS-1-i]    = m_px[i][2:0];
        m_fr[a+SR][COLS-1-i] = m_px[i][5:3];
      end
      m_mask[a] = 1'b1;
      if (&m_mask) begin
        m_frames = (m_frames + 1) % 65536;
        m_done++;
        m_mask = '0;
      end
    end else begin
      m_len = 1;
    end
    m_px.delete();
  endfunction

  // ---------------- scoreboard + monitor ----------------
  int    exp_q [$];
  string tag_q [$];
  logic  rd_vld   = 1'b0;
  logic  rd_vld_d = 1'b0;
  int    done_seen = 0;

  always @(posedge clk) rd_vld_d <= rd_vld;

  always @(negedge clk) begin
    if (rd_vld_d) begin
      if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
      else chk(tag_q.pop_front(), int'(rd_rgb), exp_q.pop_front());
    end
    if (frame_done) done_seen++;
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; outclk = 1'b0; lat = 1'b0; oe = 1'b1;
    m_reset();
    tick(3);
    chk("rst rd_rgb", int'(rd_rgb), 0);
    chk("rst frame_done", int'(frame_done), 0);
    chk("rst frame_cnt", int'(frame_cnt), 0);
    chk("rst len_err", int'(len_err), 0);
    chk("rst oe_err", int'(oe_err), 0);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic pix(input logic [5:0] d, input bit wl);
    @(negedge clk);
    rgb = d; outclk = 1'b1;
    if (wl) lat = 1'b1;
    @(negedge clk);
    outclk = 1'b0; lat = 1'b0;
    m_pix(d);
    if (wl) begin
      m_latch(int'(abc), oe);
      tick(4);
    end
  endtask

  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++) pix(6'($urandom), 1'b0);
  endtask

  task automatic latch(input int a, input logic oev);
    @(negedge clk);
    abc = 3'(a); oe = oev; lat = 1'b1;
    @(negedge clk);
    lat = 1'b0;
    tick(4);
    oe = 1'b1;
    m_latch(a, oev);
  endtask

  task automatic read_row(input int r);
    for (int c = 0; c < COLS; c++) begin
      @(negedge clk);
      rd_row = 4'(r); rd_col = 5'(c); rd_vld = 1'b1;
      exp_q.push_back(int'(m_fr[r][c]));
      tag_q.push_back($sformatf("rd row%0d col%0d", r, c));
    end
    @(negedge clk);
    rd_vld = 1'b0;
    tick(1);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, " len_err"}, int'(len_err), int'(m_len));
    chk({tag, " oe_err"}, int'(oe_err), int'(m_oe));
    chk({tag, " frame_cnt"}, int'(frame_cnt), m_frames);
    chk({tag, " frame_done pulses"}, done_seen, m_done);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    m_reset();
    m_done = 0;
    do_reset();

    // First latch only aligns the receiver.
    latch(0, 1'b1);

    // Uniform row: upper 3'b100, lower 3'b001.
    for (int i = 0; i < COLS; i++) pix(6'b001_100, 1'b0);
    latch(3, 1'b1);
    read_row(3);
    read_row(11);
    check_flags("uniform");

    // Column-index ramp shows the first-in pixel lands at the last column.
    for (int i = 0; i < COLS; i++) pix({3'b000, 3'(i % 8)}, 1'b0);
    latch(5, 1'b1);
    read_row(5);

    // 32nd pixel and latch rising together.
    abc = 3'd6;
    rand_pixels(COLS - 1);
    pix(6'($urandom), 1'b1);
    read_row(6);
    read_row(14);
    check_flags("same-cycle");

    // Full frame in reverse address order: one pulse, after the 8th commit.
    do_reset();
    latch(0, 1'b1);
    base = done_seen;
    for (int a = SR - 1; a >= 0; a--) begin
      rand_pixels(COLS);
      latch(a, 1'b1);
      chk($sformatf("frame_done after abc%0d", a), done_seen - base, (a == 0) ? 1 : 0);
    end
    check_flags("frame");
    for (int r = 0; r < NR; r++) read_row(r);

    // Short and long rows leave the target untouched.
    rand_pixels(COLS - 1);
    latch(2, 1'b1);
    check_flags("short");
    read_row(2);
    read_row(10);
    rand_pixels(COLS + 1);
    latch(4, 1'b1);
    check_flags("long");
    read_row(4);
    read_row(12);

    // Latch while the display is enabled; commit still happens.
    rand_pixels(COLS);
    latch(1, 1'b0);
    check_flags("oe");
    read_row(1);
    read_row(9);

    // Randomized rows with occasional bad lengths.
    for (int k = 0; k < 30; k++) begin
      int a, n;
      a = $urandom_range(0, SR - 1);
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(COLS - 2, COLS + 2) : COLS;
      rand_pixels(n);
      latch(a, ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1);
    end
    check_flags("random");
    for (int k = 0; k < 4; k++) read_row($urandom_range(0, NR - 1));

    // Reset mid-row: everything clears and the next latch only re-syncs.
    rand_pixels(10);
    do_reset();
    rand_pixels(COLS);
    latch(3, 1'b1);
    read_row(3);
    read_row(11);
    check_flags("post-reset sync");
    rand_pixels(COLS);
    latch(3, 1'b1);
    read_row(3);
    read_row(11);
    check_flags("post-reset commit");

    tick(3);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_hub75_capture

`default_nettype wire
